encode83_seq: RTL and testbench



---
 rtl/encode83_seq_if.sv | 33 +++
 rtl/encode83_seq.sv | 91 +++++++++
 tb/tb_encode83_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/encode83_seq_if.sv
// Handshake bundle for encode83_seq: vector input side and beat output side.
// With ENCODE83_COUNT_EN defined the bundle also carries cnt, the captured vector's popcount.
interface encode83_seq_if;
    logic [7:0] Y;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] A;
    logic       out_none;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
`ifdef ENCODE83_COUNT_EN
    logic [3:0] cnt;

    modport master (
        output Y, in_valid, out_ready,
        input  in_ready, A, out_none, out_last, out_valid, cnt
    );
    modport slave (
        input  Y, in_valid, out_ready,
        output in_ready, A, out_none, out_last, out_valid, cnt
    );
`else
    modport master (
        output Y, in_valid, out_ready,
        input  in_ready, A, out_none, out_last, out_valid
    );
    modport slave (
        input  Y, in_valid, out_ready,
        output in_ready, A, out_none, out_last, out_valid
    );
`endif
endinterface

// File: rtl/encode83_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits the index of each set bit, one beat each.
// Define ENCODE83_COUNT_EN to add cnt, the popcount of the captured vector, registered at capture.
module encode83_seq #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    encode83_seq_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t     state, state_nxt;
    logic [7:0] pend, pend_nxt;
    logic [2:0] idx;
    logic       at_most_one;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; combinational blocks use =.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Last match in scan order wins, so the scan runs from lowest to highest priority.
    always_comb begin
        idx = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (pend[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (pend[i]) idx = 3'(i);
        end
    end

    assign at_most_one = ((pend & (pend - 8'd1)) == 8'd0);

    always_comb begin
        // NOTE: defaults assigned first so no path through the case can infer a latch.
        state_nxt = state;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    pend_nxt  = bus.Y;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    pend_nxt = pend & ~(8'd1 << idx);
                    if (at_most_one) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == SEND);
    assign bus.A         = (state == SEND) ? idx : 3'd0;
    assign bus.out_none  = (state == SEND) && (pend == 8'd0);
    assign bus.out_last  = (state == SEND) && at_most_one;

`ifdef ENCODE83_COUNT_EN
    logic [3:0] cnt_q;
    logic [3:0] pop_y;

    always_comb begin
        pop_y = '0;
        for (int i = 0; i < 8; i++)
            pop_y = pop_y + 4'(bus.Y[i]);
    end

    // Held through IDLE; only a new capture replaces it.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (state == IDLE && bus.in_valid)
            cnt_q <= pop_y;
    end

    assign bus.cnt = cnt_q;
`else
    // Without the count option there is no popcount state at all.
`endif
endmodule

// File: tb/tb_encode83_seq.sv
// Scoreboard bench for encode83_seq: two instances (HIGH_FIRST=1 and 0) run in lockstep on shared stimulus.
// Expected beats come from a set-bit list model and are popped by per-instance monitors.
module tb_encode83_seq;
    typedef struct {
        logic [2:0] a;
        logic       none;
        logic       last;
        logic [3:0] cnt;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_drv;
    logic       in_valid_drv;
    logic       out_ready_drv;
    logic       rand_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    beat_t q_h[$];
    beat_t q_l[$];

    encode83_seq_if bus_h ();
    encode83_seq_if bus_l ();

    assign bus_h.Y         = y_drv;
    assign bus_h.in_valid  = in_valid_drv;
    assign bus_h.out_ready = out_ready_drv;
    assign bus_l.Y         = y_drv;
    assign bus_l.in_valid  = in_valid_drv;
    assign bus_l.out_ready = out_ready_drv;

    encode83_seq #(.HIGH_FIRST(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
    encode83_seq #(.HIGH_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Model: list the set bits, order them by priority, one beat per entry; empty vector gives one none-beat.
    function automatic void push_expect(input logic [7:0] y);
        int    idx_list[$];
        int    n;
        beat_t b;
        for (int i = 0; i < 8; i++)
            if (y[i]) idx_list.push_back(i);
        n = idx_list.size();
        if (n == 0) begin
            b = '{a: 3'd0, none: 1'b1, last: 1'b1, cnt: 4'd0};
            q_h.push_back(b);
            q_l.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                b = '{a: 3'(idx_list[n-1-k]), none: 1'b0, last: (k == n-1), cnt: 4'(n)};
                q_h.push_back(b);
                b = '{a: 3'(idx_list[k]), none: 1'b0, last: (k == n-1), cnt: 4'(n)};
                q_l.push_back(b);
            end
        end
    endfunction

    // Monitors: a beat held under backpressure is compared each cycle and popped only when it transfers.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus_h.out_valid) begin
            check("h_beat_expected", int'(q_h.size() != 0), 1);
            if (q_h.size() != 0) begin
                e = q_h[0];
                check("h_A", int'(bus_h.A), int'(e.a));
                check("h_out_none", int'(bus_h.out_none), int'(e.none));
                check("h_out_last", int'(bus_h.out_last), int'(e.last));
`ifdef ENCODE83_COUNT_EN
                check("h_cnt", int'(bus_h.cnt), int'(e.cnt));
`endif
                if (out_ready_drv) void'(q_h.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus_l.out_valid) begin
            check("l_beat_expected", int'(q_l.size() != 0), 1);
            if (q_l.size() != 0) begin
                e = q_l[0];
                check("l_A", int'(bus_l.A), int'(e.a));
                check("l_out_none", int'(bus_l.out_none), int'(e.none));
                check("l_out_last", int'(bus_l.out_last), int'(e.last));
`ifdef ENCODE83_COUNT_EN
                check("l_cnt", int'(bus_l.cnt), int'(e.cnt));
`endif
                if (out_ready_drv) void'(q_l.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready_drv = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] y);
        int waited = 0;
        while (!(bus_h.in_ready && bus_l.in_ready) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("send_in_ready_budget", int'(waited < 100), 1);
        y_drv        = y;
        in_valid_drv = 1'b1;
        push_expect(y);
        @(posedge clk);
        #1;
        in_valid_drv = 1'b0;
        y_drv        = 8'($urandom);
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!(bus_h.in_ready && q_h.size() == 0 && q_l.size() == 0) && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_budget", int'(waited < 200), 1);
    endtask

    // Cycles from capture until in_ready returns, with out_ready held high.
    task automatic send_latency(input logic [7:0] y, input int exp_cycles);
        int lat = 0;
        send(y);
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus_h.in_ready && lat < 50);
        check("latency", lat, exp_cycles);
        check("latency_lockstep", int'(bus_l.in_ready), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, int'(bus_h.in_ready), 1);
        check({tag, "_out_valid"}, int'(bus_h.out_valid), 0);
        check({tag, "_A"}, int'(bus_h.A), 0);
        check({tag, "_out_none"}, int'(bus_h.out_none), 0);
        check({tag, "_out_last"}, int'(bus_h.out_last), 0);
        check({tag, "_l_in_ready"}, int'(bus_l.in_ready), 1);
        check({tag, "_l_out_valid"}, int'(bus_l.out_valid), 0);
`ifdef ENCODE83_COUNT_EN
        check({tag, "_cnt"}, int'(bus_h.cnt), 0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        y_drv         = 8'h00;
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // Directed vectors, consumer always ready.
        out_ready_drv = 1'b1;
        send_latency(8'b1010_0100, 3);
        send_latency(8'hFF, 8);
        send_latency(8'h00, 1);
        send_latency(8'h01, 1);
        send_latency(8'h80, 1);

        // Backpressure with input noise during SEND.
        out_ready_drv = 1'b0;
        send(8'h81);
        in_valid_drv = 1'b1;
        y_drv        = 8'h3C;
        repeat (3) begin
            check("bp_out_valid", int'(bus_h.out_valid), 1);
            check("bp_in_ready", int'(bus_h.in_ready), 0);
            @(posedge clk);
            #1;
            y_drv = 8'($urandom);
        end
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b1;
        wait_idle();

        // Reset after the first beat of 0xF0 discards the rest.
        send(8'hF0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_h.delete();
        q_l.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("midreset");
        send_latency(8'h02, 1);

        // Randomized vectors with random consumer stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] y;
            y = 8'($urandom);
            if (n % 13 == 0) y = 8'h00;
            if (n % 17 == 5) y = 8'hFF;
            send(y);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        rand_ready    = 1'b0;
        #1;
        out_ready_drv = 1'b1;
        wait_idle();

        check("final_queue_h", q_h.size(), 0);
        check("final_queue_l", q_l.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "timeout");
    end
endmodule
